load_data_aligner_wb: RTL and testbench

LOAD_DATA_ALIGNER_WB -- requirements
Module: load_data_aligner_wb

---
 rtl/load_data_aligner_wb_pkg.sv | 22 ++
 rtl/load_data_aligner_wb_extract.sv | 45 ++++
 rtl/load_data_aligner_wb.sv | 79 +++++++
 tb/tb_load_data_aligner_wb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_data_aligner_wb_pkg.sv
// Shared load/store type encodings and the buffered write-back entry format.
// The store-side formatter imports the same encodings from here.
package load_data_aligner_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LH  = 3'd2,
    LT_LBU = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              misalign;
  } wb_entry_t;

endpackage

// File: rtl/load_data_aligner_wb_extract.sv
// Combinational lane select and sign/zero extension of a raw memory word.
// Reserved load types fall through to the word path, including its alignment rule.
module load_lane_extract
  import load_data_aligner_wb_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [2:0]        load_type_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o     = '0;
    misalign_o = 1'b0;
    case (load_type_i)
      LT_LB:  data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH: begin
        if (addr_lo_i[0]) misalign_o = 1'b1;
        else              data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      end
      LT_LHU: begin
        if (addr_lo_i[0]) misalign_o = 1'b1;
        else              data_o = {{(DATA_W-16){1'b0}}, half_sel};
      end
      default: begin
        if (addr_lo_i != 2'b00) misalign_o = 1'b1;
        else                    data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_data_aligner_wb.sv
// MEM->WB load aligner: extracts the load value at accept time and holds it in a
// 2-entry skid FIFO whose head is presented directly on the out_* ports.
module load_data_aligner_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [1:0]        in_addr_lo,
  input  logic [2:0]        in_load_type,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_misalign
);
  import load_data_aligner_wb_pkg::*;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [DATA_W-1:0] ext_data;
  logic              ext_misalign;
  wb_entry_t         mem_q [DEPTH];
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              in_ready_q;
  logic              push, pop;

  load_lane_extract u_extract (
    .rdata_i     (in_rdata),
    .addr_lo_i   (in_addr_lo),
    .load_type_i (in_load_type),
    .data_o      (ext_data),
    .misalign_o  (ext_misalign)
  );

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
  end

  // in_ready is registered from the next count so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= (count_d < DEPTH_C);
      if (push) mem_q[wr_ptr_q] <= '{data: ext_data, rd: in_rd, misalign: ext_misalign};
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_data     = out_valid ? mem_q[rd_ptr_q].data     : '0;
  assign out_rd       = out_valid ? mem_q[rd_ptr_q].rd       : '0;
  assign out_misalign = out_valid ? mem_q[rd_ptr_q].misalign : 1'b0;

endmodule

// File: tb/tb_load_data_aligner_wb.sv
// Scoreboard bench for load_data_aligner_wb: accepted loads are modelled and queued,
// a negedge monitor pops and compares every output transfer.
module tb_load_data_aligner_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic [1:0]  in_addr_lo;
  logic [2:0]  in_load_type;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misalign;

  always #5 clk = ~clk;

  load_data_aligner_wb #(.DATA_W(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rdata     (in_rdata),
    .in_addr_lo   (in_addr_lo),
    .in_load_type (in_load_type),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_misalign (out_misalign)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    logic        kv;
    logic [31:0] kdata;
    logic        kmis;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_pops   = 0;
  logic        k_valid  = 1'b0;
  logic [31:0] k_data   = '0;
  logic        k_mis    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference: select the lane with shifts and extend by arithmetic wraparound.
  function automatic exp_t model(input logic [31:0] w, input logic [1:0] a,
                                 input logic [2:0] t, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] b, h;
    int          ai;
    ai = int'(a);
    b  = (w >> (ai * 8)) & 32'hFF;
    h  = (w >> ((ai / 2) * 16)) & 32'hFFFF;
    e.rd = rd; e.mis = 1'b0; e.data = '0;
    e.kv = 1'b0; e.kdata = '0; e.kmis = 1'b0;
    case (t)
      3'd1: e.data = (b >= 32'd128) ? b - 32'd256 : b;
      3'd3: e.data = b;
      3'd2: if (ai % 2 == 1) e.mis = 1'b1; else e.data = (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4: if (ai % 2 == 1) e.mis = 1'b1; else e.data = h;
      default: if (ai != 0) e.mis = 1'b1; else e.data = w;
    endcase
    return e;
  endfunction

  // Monitor: compare output transfers first, then record the accepted input.
  logic        held = 1'b0;
  logic [37:0] held_val;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (out_valid) begin
          if (held) chk("hold_stable", {26'b0, out_data, out_rd, out_misalign}, {26'b0, held_val});
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_output: actual data=%h rd=%0d required=no output", out_data, out_rd);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("out_data", {32'b0, out_data}, {32'b0, e.data});
              chk("out_rd", {59'b0, out_rd}, {59'b0, e.rd});
              chk("out_misalign", {63'b0, out_misalign}, {63'b0, e.mis});
              if (e.kv) chk("const_value", {31'b0, out_misalign, out_data}, {31'b0, e.kmis, e.kdata});
              n_pops++;
            end
          end
          held     = !out_ready;
          held_val = {out_data, out_rd, out_misalign};
        end else begin
          held = 1'b0;
          chk("idle_zero", {26'b0, out_data, out_rd, out_misalign}, 64'b0);
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e = model(in_rdata, in_addr_lo, in_load_type, in_rd);
          e.kv = k_valid; e.kdata = k_data; e.kmis = k_mis;
          k_valid = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t, input logic [4:0] rd);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_rdata = w; in_addr_lo = a; in_load_type = t; in_rd = rd;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: actual=not accepted required=accepted within 200 cycles");
    end
  endtask

  task automatic send_k(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t,
                        input logic [4:0] rd, input logic [31:0] kd, input logic km);
    k_valid = 1'b1; k_data = kd; k_mis = km;
    send(w, a, t, rd);
  endtask

  task automatic drain(input string name);
    repeat (6) begin @(posedge clk); #1; end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int unsigned p0;
    time         t0;
    bit          done;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rdata = '0; in_addr_lo = '0; in_load_type = '0; in_rd = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", {25'b0, out_valid, out_data, out_rd, out_misalign}, 64'b0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("in_ready_before_edge", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", {63'b0, in_ready}, 64'd1);

    // Directed extraction cases with known constants.
    send_k(32'h80FF7F01, 2'd3, 3'd1, 5'd1, 32'hFFFFFF80, 1'b0);
    send_k(32'h80FF7F01, 2'd3, 3'd3, 5'd2, 32'h00000080, 1'b0);
    send_k(32'h80FF7F01, 2'd2, 3'd1, 5'd3, 32'hFFFFFFFF, 1'b0);
    send_k(32'h80017FFE, 2'd2, 3'd2, 5'd4, 32'hFFFF8001, 1'b0);
    send_k(32'h80017FFE, 2'd0, 3'd4, 5'd5, 32'h00007FFE, 1'b0);
    send_k(32'h80017FFE, 2'd1, 3'd2, 5'd6, 32'h00000000, 1'b1);
    send_k(32'hDEADBEEF, 2'd0, 3'd0, 5'd17, 32'hDEADBEEF, 1'b0);
    send_k(32'hDEADBEEF, 2'd2, 3'd6, 5'd18, 32'h00000000, 1'b1);
    drain("directed_drained");

    // Stall: third load held until the consumer frees a slot.
    out_ready = 1'b0;
    fork
      begin
        send(32'h11111111, 2'd0, 3'd0, 5'd7);
        send(32'h22222222, 2'd0, 3'd0, 5'd8);
        send(32'h33333333, 2'd0, 3'd0, 5'd9);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("stall_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        chk("stall_third_held", {63'b0, in_ready}, 64'd0);
        chk("stall_buffered", 64'(exp_q.size()), 64'd2);
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("drain_one_per_cycle", {63'b0, out_valid}, 64'd1);
        end
        @(negedge clk);
        chk("drain_empty", {63'b0, out_valid}, 64'd0);
      end
    join
    drain("stall_drained");

    // Full throughput: one result per cycle, in_ready never drops.
    out_ready = 1'b1;
    p0 = n_pops;
    t0 = $time;
    fork
      for (int i = 0; i < 20; i++)
        send($urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      repeat (20) begin
        @(negedge clk);
        chk("tput_in_ready", {63'b0, in_ready}, 64'd1);
      end
    join
    chk("tput_cycles", 64'($time - t0), 64'd200);
    repeat (3) begin @(posedge clk); #1; end
    chk("tput_results", 64'(n_pops - p0), 64'd20);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(32'hAAAA5555, 2'd0, 3'd0, 5'd10);
    send(32'h5555AAAA, 2'd0, 3'd0, 5'd11);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_out", {25'b0, out_valid, out_data, out_rd, out_misalign}, 64'b0);
    chk("async_reset_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    chk("rerelease_in_ready_low", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rerelease_in_ready_high", {63'b0, in_ready}, 64'd1);
    chk("no_stale_output", {63'b0, out_valid}, 64'd0);
    repeat (3) begin @(posedge clk); #1; end

    // Random traffic with random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send($urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain("random_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
